sobel_window_ctrl: RTL and testbench

Sequencer for the 3x3 edge-detect window datapath: tracks pixel position within a frame, drives the three row line-buffer write enables and addresses, rotates which line buffer holds the newest row, and flags when the 3x3 window holds valid image data. It also holds the edge threshold and effect-mode configuration, double-buffered so changes take effect only at frame boundaries. It sits between the camera/VGA pixel-timing logic and the line-buffer/shift-register/Sobel datapath.

---
 rtl/sobel_window_ctrl.sv | 143 ++++++++++++++
 tb/tb_sobel_window_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_ctrl.sv
// Pixel-position sequencer for the 3x3 Sobel window: line-buffer enables/addresses,
// row-bank rotation, window-valid flag and frame-synchronous threshold/mode config.
module sobel_window_ctrl #(
    parameter int LINE_W  = 640,
    parameter int FRAME_H = 480,
    parameter int ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sof,
    input  logic              pix_valid,
    input  logic              cfg_wr,
    input  logic [7:0]        cfg_thresh,
    input  logic [1:0]        cfg_mode,
    output logic [2:0]        row_shift_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        bank_sel,
    output logic [12:0]       x_pos,
    output logic [12:0]       y_pos,
    output logic              win_valid,
    output logic [7:0]        thresh,
    output logic [1:0]        mode,
    output logic [1:0]        state
);

    localparam logic [12:0] X_LAST = 13'(LINE_W - 1);
    localparam logic [12:0] Y_LAST = 13'(FRAME_H - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [12:0] nx_q, ny_q;
    logic [1:0]  nbank_q;
    logic [7:0]  sh_thresh_q;
    logic [1:0]  sh_mode_q;

    logic        vld_p0;
    logic        x_end_p0;
    logic [12:0] cx_p0, cy_p0;
    logic [1:0]  cb_p0;

    // Reserved mode encoding collapses to pass-through.
    function automatic logic [1:0] sat_mode(input logic [1:0] m);
        return (m == 2'd3) ? 2'd0 : m;
    endfunction

    // Stage p0: position of the pixel being accepted this cycle (sof restarts at origin).
    always_comb begin
        vld_p0   = pix_valid && ((state_q != IDLE) || sof);
        cx_p0    = sof ? 13'd0 : nx_q;
        cy_p0    = sof ? 13'd0 : ny_q;
        cb_p0    = sof ? 2'd0  : nbank_q;
        x_end_p0 = (cx_p0 == X_LAST);
    end

    always_comb begin
        state_d = state_q;
        if (vld_p0) begin
            if (sof) begin
                state_d = FILL;
            end else begin
                case (state_q)
                    FILL:    if (x_end_p0 && (cy_p0 == 13'd1)) state_d = RUN;
                    RUN:     if (x_end_p0 && (cy_p0 == Y_LAST)) state_d = IDLE;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nx_q    <= '0;
            ny_q    <= '0;
            nbank_q <= '0;
        end else if (vld_p0) begin
            if (x_end_p0) begin
                nx_q    <= '0;
                ny_q    <= (cy_p0 == Y_LAST) ? 13'd0 : cy_p0 + 13'd1;
                nbank_q <= (cb_p0 == 2'd2) ? 2'd0 : cb_p0 + 2'd1;
            end else begin
                nx_q    <= cx_p0 + 13'd1;
                ny_q    <= cy_p0;
                nbank_q <= cb_p0;
            end
        end
    end

    // Stage p1: registered outputs describing the last accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_shift_en <= '0;
            win_valid    <= 1'b0;
            wr_addr      <= '0;
            rd_addr      <= '0;
            x_pos        <= '0;
            y_pos        <= '0;
            bank_sel     <= '0;
        end else begin
            row_shift_en <= vld_p0 ? 3'(3'b001 << cb_p0) : 3'b000;
            win_valid    <= vld_p0 && (cy_p0 >= 13'd2) && (cx_p0 >= 13'd2);
            if (vld_p0) begin
                wr_addr  <= ADDR_W'(cx_p0);
                rd_addr  <= x_end_p0 ? '0 : ADDR_W'(cx_p0 + 13'd1);
                x_pos    <= cx_p0;
                y_pos    <= cy_p0;
                bank_sel <= cb_p0;
            end
        end
    end

    // A write coinciding with sof lands in the shadow only; the old shadow goes live.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_thresh_q <= 8'h13;
            sh_mode_q   <= 2'd0;
            thresh      <= 8'h13;
            mode        <= 2'd0;
        end else begin
            if (cfg_wr) begin
                sh_thresh_q <= cfg_thresh;
                sh_mode_q   <= sat_mode(cfg_mode);
            end
            if (sof) begin
                thresh <= sh_thresh_q;
                mode   <= sh_mode_q;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Scoreboard bench for sobel_window_ctrl on an 8x4 frame: an index-based reference model
// queues expected outputs per driven cycle, compared one cycle later.
module tb_sobel_window_ctrl;

    localparam int LW = 8;
    localparam int FH = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sof, pix_valid, cfg_wr;
    logic [7:0]    cfg_thresh;
    logic [1:0]    cfg_mode;
    logic [2:0]    row_shift_en;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [1:0]    bank_sel;
    logic [12:0]   x_pos, y_pos;
    logic          win_valid;
    logic [7:0]    thresh;
    logic [1:0]    mode;
    logic [1:0]    state;

    sobel_window_ctrl #(.LINE_W(LW), .FRAME_H(FH), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .sof(sof), .pix_valid(pix_valid),
        .cfg_wr(cfg_wr), .cfg_thresh(cfg_thresh), .cfg_mode(cfg_mode),
        .row_shift_en(row_shift_en), .wr_addr(wr_addr), .rd_addr(rd_addr),
        .bank_sel(bank_sel), .x_pos(x_pos), .y_pos(y_pos), .win_valid(win_valid),
        .thresh(thresh), .mode(mode), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    se;
        logic [AW-1:0] wr;
        logic [AW-1:0] rd;
        logic [1:0]    bank;
        logic [12:0]   x;
        logic [12:0]   y;
        logic          win;
        logic [7:0]    th;
        logic [1:0]    md;
        logic [1:0]    st;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       m_hold;
    int         checks = 0;
    int         errors = 0;
    int         win_cnt = 0;
    int         m_st, m_idx;
    logic [7:0] m_th, m_sth;
    logic [1:0] m_md, m_smd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st  = 0;
        m_idx = 0;
        m_th  = 8'h13;
        m_sth = 8'h13;
        m_md  = 2'd0;
        m_smd = 2'd0;
        m_hold = '{se: 3'd0, wr: '0, rd: '0, bank: 2'd0, x: 13'd0, y: 13'd0,
                   win: 1'b0, th: 8'h13, md: 2'd0, st: 2'd0};
        sb_q.delete();
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_state"}, 32'(state), 32'd0);
        chk({pfx, "_se"}, 32'(row_shift_en), 32'd0);
        chk({pfx, "_win"}, 32'(win_valid), 32'd0);
        chk({pfx, "_wr"}, 32'(wr_addr), 32'd0);
        chk({pfx, "_rd"}, 32'(rd_addr), 32'd0);
        chk({pfx, "_x"}, 32'(x_pos), 32'd0);
        chk({pfx, "_y"}, 32'(y_pos), 32'd0);
        chk({pfx, "_bank"}, 32'(bank_sel), 32'd0);
        chk({pfx, "_thresh"}, 32'(thresh), 32'h13);
        chk({pfx, "_mode"}, 32'(mode), 32'd0);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("row_shift_en", 32'(row_shift_en), 32'(e.se));
            chk("wr_addr", 32'(wr_addr), 32'(e.wr));
            chk("rd_addr", 32'(rd_addr), 32'(e.rd));
            chk("bank_sel", 32'(bank_sel), 32'(e.bank));
            chk("x_pos", 32'(x_pos), 32'(e.x));
            chk("y_pos", 32'(y_pos), 32'(e.y));
            chk("win_valid", 32'(win_valid), 32'(e.win));
            chk("thresh", 32'(thresh), 32'(e.th));
            chk("mode", 32'(mode), 32'(e.md));
            chk("state", 32'(state), 32'(e.st));
            if (win_valid === 1'b1) win_cnt++;
        end
    endtask

    // Drive one cycle, push the model's expectation, then compare after the edge.
    task automatic step(input logic s, input logic pv, input logic cw,
                        input logic [7:0] ct, input logic [1:0] cm);
        exp_t e;
        int   px, py;
        bit   acc;
        sof = s; pix_valid = pv; cfg_wr = cw; cfg_thresh = ct; cfg_mode = cm;
        acc = pv && ((m_st != 0) || s);
        if (s) begin
            m_th = m_sth;
            m_md = m_smd;
        end
        if (cw) begin
            m_sth = ct;
            m_smd = (cm == 2'd3) ? 2'd0 : cm;
        end
        e = m_hold;
        e.se = 3'd0;
        e.win = 1'b0;
        if (acc) begin
            if (s) m_idx = 0;
            px = m_idx % LW;
            py = m_idx / LW;
            e.se   = 3'(1 << (py % 3));
            e.wr   = AW'(px);
            e.rd   = AW'((px + 1) % LW);
            e.x    = 13'(px);
            e.y    = 13'(py);
            e.bank = 2'(py % 3);
            e.win  = (px >= 2) && (py >= 2);
            m_idx++;
            if (m_idx == LW * FH) begin
                m_st = 0;
                m_idx = 0;
            end else if (m_idx >= 2 * LW) m_st = 2;
            else m_st = 1;
        end
        e.th = m_th;
        e.md = m_md;
        e.st = 2'(m_st);
        m_hold = e;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        rst_n = 1'b0;
        sof = 1'b0; pix_valid = 1'b0; cfg_wr = 1'b0; cfg_thresh = 8'h00; cfg_mode = 2'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rst_n = 1'b1;

        // pix_valid in IDLE without sof is ignored
        step(1'b0, 1'b1, 1'b0, 8'h00, 2'd0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 2'd0);

        // Frame 1: continuous pixels
        win_cnt = 0;
        step(1'b1, 1'b1, 1'b0, 8'h00, 2'd0);
        for (int i = 1; i < LW * FH; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 2'd0);
        chk("win_cnt_frame1", 32'(win_cnt), 32'd12);

        // Frame 2: back-to-back sof, mid-frame config write, pix_valid toggling in RUN
        step(1'b1, 1'b1, 1'b0, 8'h00, 2'd0);
        for (int i = 1; i < 18; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 2'd0);
        step(1'b0, 1'b1, 1'b1, 8'h40, 2'd1);
        for (int i = 0; i < 12; i++) step(1'b0, (i % 2) == 0, 1'b0, 8'h00, 2'd0);
        for (int k = 0; k < 64 && m_st != 0; k++) step(1'b0, 1'b1, 1'b0, 8'h00, 2'd0);
        chk("frame2_end_state", 32'(state), 32'd0);

        // Frame 3: cfg write on the sof cycle (mode 3), then sof mid-line at (5,2)
        step(1'b1, 1'b1, 1'b1, 8'h55, 2'd3);
        chk("thresh_after_sof2", 32'(thresh), 32'h40);
        for (int i = 1; i < 2 * LW + 5; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 2'd0);
        step(1'b1, 1'b1, 1'b0, 8'h00, 2'd0);
        chk("thresh_after_sof3", 32'(thresh), 32'h55);
        chk("mode_after_sof3", 32'(mode), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 2'd0);

        // Asynchronous reset pulse mid-cycle, then pix_valid without sof
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0, 8'h00, 2'd0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 2'd0);

        sof = 1'b0; pix_valid = 1'b0; cfg_wr = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
